// File: rtl/led_seq_pkg.sv
// Shared types for the LED pattern sequencer: pattern modes and PWM counter width.
package led_seq_pkg;
  typedef enum logic [1:0] {LED_STATIC, LED_WALK, LED_BLINK, LED_COUNT} led_mode_e;
  localparam int PWM_W = 8;
endpackage

// File: rtl/led_prescaler.sv
// Step-rate prescaler: tick is high in the enabled cycle where cnt reaches PRESCALE-1.
module led_prescaler #(
  parameter int PRESCALE = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(PRESCALE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= tick ? '0 : cnt + CW'(1);
  end
endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer (static/walk/blink/count) on LED[LED_MSB:LED_LSB].
// Optional LED_PWM_EN adds an 8-bit duty input that gates the driven LEDs.
module led_pattern_sequencer import led_seq_pkg::*; #(
  parameter int          LED_LSB       = 2,
  parameter int          LED_MSB       = 5,
  parameter int          PRESCALE      = 1000000,
  parameter logic [63:0] RESET_PATTERN = 64'b1010
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             mode,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0]       duty,
`endif
  output logic [LED_MSB:LED_LSB] LED,
  output logic                   wrap
);
  localparam int W = LED_MSB - LED_LSB + 1;
  localparam logic [W-1:0] RST_PAT = W'(RESET_PATTERN);

  led_mode_e      mode_e, mode_q;
  logic [W-1:0]   pat, pat_d;
  logic           wrap_d, mode_chg, tick;

  assign mode_e   = led_mode_e'(mode);
  assign mode_chg = (mode_e != mode_q);

  function automatic logic [W-1:0] start_val(led_mode_e m);
    case (m)
      LED_WALK:  return W'(1);
      LED_BLINK: return '1;
      LED_COUNT: return '0;
      default:   return RST_PAT;
    endcase
  endfunction

  // A mode change also restarts the step period so the new pattern gets a full first step.
  led_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (mode_chg),
    .tick(tick)
  );

  always_comb begin
    pat_d  = pat;
    wrap_d = 1'b0;
    if (mode_chg) begin
      pat_d = start_val(mode_e);
    end else if (tick) begin
      case (mode_q)
        LED_WALK: begin
          // Shift-and-or rotate stays legal for W==1, where it simply holds the bit.
          pat_d  = (pat << 1) | (pat >> (W - 1));
          wrap_d = pat[W-1];
        end
        LED_BLINK: pat_d = ~pat;
        LED_COUNT: begin
          pat_d  = pat + W'(1);
          wrap_d = &pat;
        end
        default: pat_d = pat;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= LED_STATIC;
      pat    <= RST_PAT;
      wrap   <= 1'b0;
    end else begin
      mode_q <= mode_e;
      pat    <= pat_d;
      wrap   <= wrap_d;
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  assign LED = pat & {W{pwm_cnt < duty}};
`else
  assign LED = pat;
`endif
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a random run
// against an arithmetic reference model (LED_LSB=2, LED_MSB=5, PRESCALE=4, RESET_PATTERN=1010).
module tb_led_pattern_sequencer;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] mode;
  logic [5:2] LED;
  logic       wrap;
`ifdef LED_PWM_EN
  logic [7:0] duty = 8'd255;
`endif

  always #5 clk = ~clk;

  led_pattern_sequencer #(
    .LED_LSB(2), .LED_MSB(5), .PRESCALE(P), .RESET_PATTERN(64'b1010)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .mode(mode),
`ifdef LED_PWM_EN
    .duty(duty),
`endif
    .LED (LED),
    .wrap(wrap)
  );

  int tests = 0, fails = 0;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    int         n;
    logic [3:0] led;
    logic       wrap;
  } vec_t;
  vec_t tv[$];

  // Reference model: pattern kept as a plain integer, steps counted arithmetically.
  int m_mode, m_cnt, m_val;
  bit m_wrap;

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_val = 10; m_wrap = 0;
  endtask

  task automatic model_edge(input bit e, input int md);
    m_wrap = 0;
    if (md != m_mode) begin
      m_mode = md;
      m_cnt  = 0;
      m_val  = (md == 0) ? 10 : (md == 1) ? 1 : (md == 2) ? 15 : 0;
    end else if (e) begin
      if (m_cnt == P - 1) begin
        m_cnt = 0;
        case (m_mode)
          1: if (m_val == 8) begin m_val = 1; m_wrap = 1; end else m_val = m_val * 2;
          2: m_val = 15 - m_val;
          3: begin m_val = (m_val + 1) % 16; m_wrap = (m_val == 0); end
          default: ;
        endcase
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [3:0] el, input logic ew);
    tests++;
    if (LED !== el || wrap !== ew) begin
      fails++;
      $display("FAIL %s: got LED=%b wrap=%b, expected LED=%b wrap=%b", nm, LED, wrap, el, ew);
    end
  endtask

  task automatic chk_wrap(input string nm, input logic ew);
    tests++;
    if (wrap !== ew) begin
      fails++;
      $display("FAIL %s: got wrap=%b, expected wrap=%b", nm, wrap, ew);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // WALK: start, then one step every 4 clks, wrap pulse after 1000->0001
    tv.push_back('{1'b1, 2'd1, 1,  4'b0001, 1'b0});
    tv.push_back('{1'b1, 2'd1, 3,  4'b0001, 1'b0});
    tv.push_back('{1'b1, 2'd1, 1,  4'b0010, 1'b0});
    tv.push_back('{1'b1, 2'd1, 4,  4'b0100, 1'b0});
    tv.push_back('{1'b1, 2'd1, 4,  4'b1000, 1'b0});
    tv.push_back('{1'b1, 2'd1, 4,  4'b0001, 1'b1});
    tv.push_back('{1'b1, 2'd1, 1,  4'b0001, 1'b0});
    // COUNT: 0..15 then wrap to 0
    tv.push_back('{1'b1, 2'd3, 1,  4'b0000, 1'b0});
    tv.push_back('{1'b1, 2'd3, 4,  4'b0001, 1'b0});
    tv.push_back('{1'b1, 2'd3, 56, 4'b1111, 1'b0});
    tv.push_back('{1'b1, 2'd3, 4,  4'b0000, 1'b1});
    tv.push_back('{1'b1, 2'd3, 1,  4'b0000, 1'b0});
    // BLINK with en dropped for 10 clks mid-period
    tv.push_back('{1'b1, 2'd2, 1,  4'b1111, 1'b0});
    tv.push_back('{1'b1, 2'd2, 2,  4'b1111, 1'b0});
    tv.push_back('{1'b0, 2'd2, 10, 4'b1111, 1'b0});
    tv.push_back('{1'b1, 2'd2, 1,  4'b1111, 1'b0});
    tv.push_back('{1'b1, 2'd2, 1,  4'b0000, 1'b0});

    rst = 1'b1; en = 1'b0; mode = 2'd0;
    repeat (2) cyc();
    chk("reset", 4'b1010, 1'b0);
    rst = 1'b0;

    foreach (tv[i]) begin
      en   = tv[i].en;
      mode = tv[i].mode;
      for (int k = 0; k < tv[i].n; k++) begin
        cyc();
        if (k < tv[i].n - 1) chk_wrap($sformatf("vec%0d_wrap_c%0d", i, k), 1'b0);
        else                 chk($sformatf("vec%0d", i), tv[i].led, tv[i].wrap);
      end
    end

    // Async reset while a wrap pulse is visible, with no clock edge in between
    en = 1'b1; mode = 2'd1;
    cyc();
    repeat (16) cyc();
    chk("walk_wrap_before_rst", 4'b0001, 1'b1);
    #2 rst = 1'b1;
    #1 chk("async_rst", 4'b1010, 1'b0);
    mode = 2'd0;
    cyc();
    rst = 1'b0;

    // Mode change coinciding with a tick: load start value, no rotate
    mode = 2'd1;
    cyc();
    repeat (3) cyc();
    chk("walk_cnt3", 4'b0001, 1'b0);
    mode = 2'd0;
    cyc();
    chk("tick_mode_chg", 4'b1010, 1'b0);
    // Mode change clears the prescaler: first COUNT step needs a full period
    mode = 2'd1;
    cyc();
    repeat (3) cyc();
    mode = 2'd3;
    cyc();
    repeat (3) cyc();
    chk("cnt_cleared", 4'b0000, 1'b0);
    cyc();
    chk("count_first", 4'b0001, 1'b0);

    // Random run against the reference model
    rst = 1'b1; mode = 2'd0; en = 1'b0;
    cyc();
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) mode = 2'($urandom_range(0, 3));
      cyc();
      if (rst) model_reset();
      else     model_edge(en, int'(mode));
      chk($sformatf("rand_c%0d", c), 4'(m_val), m_wrap);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
